writeback_stage: RTL and testbench

Memory/writeback (MW) pipeline stage of each core, directly upstream of the register file. It captures retiring instructions from the execute/memory boundary, waits for variable-latency load data, and presents `W_result` / `MW_insn_dst` / `W_we` to the register file write port. It also exports the pending load destination to decode for hazard stalls, plus a saturating memory-stall counter and a sticky error flag.

---
 rtl/writeback_stage_pkg.sv | 13 +
 rtl/sat_counter.sv | 32 +++
 rtl/writeback_stage.sv | 119 +++++++++++
 tb/tb_writeback_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared core defines for the memory/writeback stage: data widths and FSM encoding.
package writeback_stage_pkg;

  localparam int REG_SIZE     = 32;
  localparam int REG_PTR_SIZE = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WB       = 2'd1,
    WAIT_MEM = 2'd2
  } wb_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; reusable for core performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Increment when enabled, holding at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/writeback_stage.sv
// Memory/writeback pipeline stage: captures retiring instructions, waits for
// load data, and drives the register file write port.
//
// state    | meaning
// ---------+---------------------------------------------
// IDLE     | no result held, nothing written
// WB       | latched result is written this cycle
// WAIT_MEM | load accepted, waiting for mem_rsp_valid
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int CORE_NUM = 0,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    XM_valid,
  output logic                    XM_ready,
  input  logic [REG_SIZE-1:0]     XM_result,
  input  logic [REG_PTR_SIZE-1:0] XM_dst,
  input  logic                    XM_wb,
  input  logic                    XM_is_load,
  input  logic                    mem_rsp_valid,
  input  logic [REG_SIZE-1:0]     mem_rsp_data,
  output logic                    W_we,
  output logic [REG_SIZE-1:0]     W_result,
  output logic [REG_PTR_SIZE-1:0] MW_insn_dst,
  output logic                    pend_valid,
  output logic [REG_PTR_SIZE-1:0] pend_dst,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic                    err_rsp
);

  // CORE_NUM only names the instance for debug; reject nonsense values.
  if (CORE_NUM < 0) begin : g_core_num_check
    $error("writeback_stage: CORE_NUM must be non-negative");
  end

  wb_state_e               state_q, state_d;
  logic [REG_SIZE-1:0]     res_q, res_d;
  logic [REG_PTR_SIZE-1:0] dst_q, dst_d;
  logic                    wb_q, wb_d;
  logic                    err_q, err_d;
  logic                    accept;
  logic                    stall_en;

  // Ready depends on state only, so upstream never sees a combinational loop.
  assign XM_ready = (state_q != WAIT_MEM);
  assign accept   = XM_valid & XM_ready;

  // Next-state and datapath capture.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    dst_d   = dst_q;
    wb_d    = wb_q;
    case (state_q)
      IDLE, WB: begin
        if (accept) begin
          dst_d = XM_dst;
          wb_d  = XM_wb;
          if (XM_is_load) begin
            state_d = WAIT_MEM;
          end else begin
            res_d   = XM_result;
            state_d = WB;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_MEM: begin
        if (mem_rsp_valid) begin
          res_d   = mem_rsp_data;
          state_d = WB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A response with no load outstanding is dropped but remembered.
  assign err_d    = err_q | (mem_rsp_valid & (state_q != WAIT_MEM));
  assign stall_en = (state_q == WAIT_MEM) & ~mem_rsp_valid;

  // State and latched instruction registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      dst_q   <= '0;
      wb_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      dst_q   <= dst_d;
      wb_q    <= wb_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk),
    .rst_ni(reset),
    .en_i  (stall_en),
    .cnt_o (stall_cnt)
  );

  assign W_we        = (state_q == WB) & wb_q;
  assign W_result    = res_q;
  assign MW_insn_dst = dst_q;
  assign pend_valid  = (state_q == WAIT_MEM);
  assign pend_dst    = pend_valid ? dst_q : '0;
  assign err_rsp     = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a random run
// against a cycle-level reference model.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    XM_valid;
  logic                    XM_ready;
  logic [REG_SIZE-1:0]     XM_result;
  logic [REG_PTR_SIZE-1:0] XM_dst;
  logic                    XM_wb;
  logic                    XM_is_load;
  logic                    mem_rsp_valid;
  logic [REG_SIZE-1:0]     mem_rsp_data;
  logic                    W_we;
  logic [REG_SIZE-1:0]     W_result;
  logic [REG_PTR_SIZE-1:0] MW_insn_dst;
  logic                    pend_valid;
  logic [REG_PTR_SIZE-1:0] pend_dst;
  logic [15:0]             stall_cnt;
  logic                    err_rsp;

  // Second instance with a 2-bit counter to observe saturation.
  logic                    s_ready, s_we, s_pend_valid, s_err;
  logic [REG_SIZE-1:0]     s_result;
  logic [REG_PTR_SIZE-1:0] s_dst, s_pend_dst;
  logic [1:0]              s_stall_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: what the stage is holding after each clock edge.
  bit                    m_loading;
  bit                    m_present;
  bit                    m_wb;
  logic [REG_SIZE-1:0]   m_data;
  logic [REG_PTR_SIZE-1:0] m_dst;
  int                    m_stall;
  bit                    m_err;

  always #5 clk = ~clk;

  writeback_stage #(.CORE_NUM(0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .XM_valid(XM_valid), .XM_ready(XM_ready),
    .XM_result(XM_result), .XM_dst(XM_dst), .XM_wb(XM_wb), .XM_is_load(XM_is_load),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .W_we(W_we),
    .W_result(W_result), .MW_insn_dst(MW_insn_dst), .pend_valid(pend_valid),
    .pend_dst(pend_dst), .stall_cnt(stall_cnt), .err_rsp(err_rsp)
  );

  writeback_stage #(.CORE_NUM(1), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .XM_valid(XM_valid), .XM_ready(s_ready),
    .XM_result(XM_result), .XM_dst(XM_dst), .XM_wb(XM_wb), .XM_is_load(XM_is_load),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .W_we(s_we),
    .W_result(s_result), .MW_insn_dst(s_dst), .pend_valid(s_pend_valid),
    .pend_dst(s_pend_dst), .stall_cnt(s_stall_cnt), .err_rsp(s_err)
  );

  task automatic model_reset();
    m_loading = 0; m_present = 0; m_wb = 0; m_data = '0; m_dst = '0; m_stall = 0; m_err = 0;
  endtask

  task automatic idle_inputs();
    XM_valid = 0; XM_result = '0; XM_dst = '0; XM_wb = 0; XM_is_load = 0;
    mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  // Drive one cycle of inputs (called just after a falling edge), advance the
  // model through the rising edge, and return at the next falling edge.
  task automatic cycle(input logic v, input logic [REG_SIZE-1:0] res,
                       input logic [REG_PTR_SIZE-1:0] dst, input logic wb,
                       input logic ld, input logic rv, input logic [REG_SIZE-1:0] rd);
    XM_valid = v; XM_result = res; XM_dst = dst; XM_wb = wb; XM_is_load = ld;
    mem_rsp_valid = rv; mem_rsp_data = rd;
    if (m_loading) begin
      if (rv) begin
        m_loading = 0; m_present = 1; m_data = rd;
      end else begin
        m_present = 0;
        if (m_stall < 65535) m_stall++;
      end
    end else begin
      if (rv) m_err = 1;
      if (v) begin
        m_dst = dst; m_wb = wb;
        if (ld) begin
          m_loading = 1; m_present = 0;
        end else begin
          m_data = res; m_present = 1;
        end
      end else begin
        m_present = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 0;
    XM_valid = 1; XM_result = 32'hDEAD; XM_dst = 5'd3; XM_wb = 1; XM_is_load = 0;
    @(negedge clk);
    @(negedge clk);
    total++; if (W_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b exp=0", W_we); end
    total++; if (W_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", W_result); end
    total++; if (MW_insn_dst !== 5'd0) begin bad++; $display("FAIL reset_dst got=%0d exp=0", MW_insn_dst); end
    total++; if (pend_valid !== 1'b0 || pend_dst !== 5'd0) begin bad++; $display("FAIL reset_pend got=%0b/%0d exp=0/0", pend_valid, pend_dst); end
    total++; if (stall_cnt !== 16'd0 || err_rsp !== 1'b0) begin bad++; $display("FAIL reset_cnt_err got=%0d/%0b exp=0/0", stall_cnt, err_rsp); end
    total++; if (XM_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", XM_ready); end
    idle_inputs();
    model_reset();
    reset = 1;
  endtask

  task automatic test_alu_stream();
    logic [REG_SIZE-1:0] vals[3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, vals[i], REG_PTR_SIZE'(i + 1), 1, 0, 0, '0);
      total++; if (W_we !== 1'b1) begin bad++; $display("FAIL alu_we[%0d] got=%0b exp=1", i, W_we); end
      total++; if (W_result !== vals[i] || MW_insn_dst !== REG_PTR_SIZE'(i + 1)) begin bad++; $display("FAIL alu_data[%0d] got=%h/%0d exp=%h/%0d", i, W_result, MW_insn_dst, vals[i], i + 1); end
      total++; if (XM_ready !== 1'b1) begin bad++; $display("FAIL alu_ready[%0d] got=%0b exp=1", i, XM_ready); end
    end
    cycle(0, '0, '0, 0, 0, 0, '0);
    total++; if (W_we !== 1'b0) begin bad++; $display("FAIL alu_idle_we got=%0b exp=0", W_we); end
  endtask

  task automatic test_load();
    do_reset();
    cycle(1, 32'hBAD, 5'd5, 1, 1, 0, '0);
    for (int i = 0; i < 4; i++) begin
      total++; if (pend_valid !== 1'b1 || pend_dst !== 5'd5 || XM_ready !== 1'b0) begin bad++; $display("FAIL load_pend[%0d] got=%0b/%0d/%0b exp=1/5/0", i, pend_valid, pend_dst, XM_ready); end
      total++; if (W_we !== 1'b0) begin bad++; $display("FAIL load_wait_we[%0d] got=%0b exp=0", i, W_we); end
      cycle(0, '0, '0, 0, 0, (i == 3), 32'hA5);
    end
    total++; if (W_we !== 1'b1 || W_result !== 32'hA5 || MW_insn_dst !== 5'd5) begin bad++; $display("FAIL load_wb got=%0b/%h/%0d exp=1/a5/5", W_we, W_result, MW_insn_dst); end
    total++; if (stall_cnt !== 16'd3 || s_stall_cnt !== 2'd3) begin bad++; $display("FAIL load_stall got=%0d/%0d exp=3/3", stall_cnt, s_stall_cnt); end
    total++; if (XM_ready !== 1'b1 || pend_valid !== 1'b0 || pend_dst !== 5'd0) begin bad++; $display("FAIL load_release got=%0b/%0b/%0d exp=1/0/0", XM_ready, pend_valid, pend_dst); end
    total++; if (err_rsp !== 1'b0) begin bad++; $display("FAIL load_err got=%0b exp=0", err_rsp); end
  endtask

  task automatic test_alu_while_pending();
    do_reset();
    cycle(1, '0, 5'd7, 1, 1, 0, '0);
    cycle(1, 32'h99, 5'd9, 1, 0, 0, '0);
    total++; if (XM_ready !== 1'b0 || W_we !== 1'b0) begin bad++; $display("FAIL pend_block got=%0b/%0b exp=0/0", XM_ready, W_we); end
    cycle(1, 32'h99, 5'd9, 1, 0, 1, 32'h77);
    total++; if (W_we !== 1'b1 || W_result !== 32'h77 || MW_insn_dst !== 5'd7) begin bad++; $display("FAIL pend_load_wb got=%0b/%h/%0d exp=1/77/7", W_we, W_result, MW_insn_dst); end
    cycle(1, 32'h99, 5'd9, 1, 0, 0, '0);
    total++; if (W_we !== 1'b1 || W_result !== 32'h99 || MW_insn_dst !== 5'd9) begin bad++; $display("FAIL pend_alu_wb got=%0b/%h/%0d exp=1/99/9", W_we, W_result, MW_insn_dst); end
    cycle(0, '0, '0, 0, 0, 0, '0);
    total++; if (W_we !== 1'b0) begin bad++; $display("FAIL pend_single_write got=%0b exp=0", W_we); end
  endtask

  task automatic test_unexpected_rsp();
    do_reset();
    cycle(0, '0, '0, 0, 0, 1, 32'hFF);
    total++; if (err_rsp !== 1'b1 || W_we !== 1'b0 || W_result !== 32'h0) begin bad++; $display("FAIL spur_rsp got=%0b/%0b/%h exp=1/0/0", err_rsp, W_we, W_result); end
    repeat (3) cycle(0, '0, '0, 0, 0, 0, '0);
    total++; if (err_rsp !== 1'b1) begin bad++; $display("FAIL spur_sticky got=%0b exp=1", err_rsp); end
    // A load without wb still waits and retires without a write.
    cycle(1, '0, 5'd12, 0, 1, 0, '0);
    total++; if (pend_valid !== 1'b1 || pend_dst !== 5'd12) begin bad++; $display("FAIL nowb_pend got=%0b/%0d exp=1/12", pend_valid, pend_dst); end
    cycle(0, '0, '0, 0, 0, 1, 32'h5A);
    total++; if (W_we !== 1'b0 || W_result !== 32'h5A || pend_valid !== 1'b0) begin bad++; $display("FAIL nowb_retire got=%0b/%h/%0b exp=0/5a/0", W_we, W_result, pend_valid); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    cycle(1, '0, 5'd4, 1, 1, 0, '0);
    repeat (6) cycle(0, '0, '0, 0, 0, 0, '0);
    total++; if (stall_cnt !== 16'd6 || s_stall_cnt !== 2'd3) begin bad++; $display("FAIL abort_stall got=%0d/%0d exp=6/3", stall_cnt, s_stall_cnt); end
    #2 reset = 0;
    #1;
    total++; if (pend_valid !== 1'b0 || stall_cnt !== 16'd0 || XM_ready !== 1'b1) begin bad++; $display("FAIL abort_async got=%0b/%0d/%0b exp=0/0/1", pend_valid, stall_cnt, XM_ready); end
    @(negedge clk);
    model_reset();
    reset = 1;
    cycle(0, '0, '0, 0, 0, 1, 32'hC3);
    total++; if (W_we !== 1'b0 || err_rsp !== 1'b1 || W_result !== 32'h0) begin bad++; $display("FAIL abort_late_rsp got=%0b/%0b/%h exp=0/1/0", W_we, err_rsp, W_result); end
  endtask

  task automatic test_random();
    logic v, ld, wb, rv;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 9) < 6);
      ld = ($urandom_range(0, 9) < 4);
      wb = ($urandom_range(0, 3) != 0);
      rv = m_loading ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 29) == 0);
      cycle(v, $urandom, REG_PTR_SIZE'($urandom), wb, ld, rv, $urandom);
      total++; if (W_we !== (m_present & m_wb)) begin bad++; $display("FAIL rnd_we[%0d] got=%0b exp=%0b", i, W_we, m_present & m_wb); end
      total++; if (W_result !== m_data || MW_insn_dst !== m_dst) begin bad++; $display("FAIL rnd_data[%0d] got=%h/%0d exp=%h/%0d", i, W_result, MW_insn_dst, m_data, m_dst); end
      total++; if (pend_valid !== m_loading || pend_dst !== (m_loading ? m_dst : 5'd0) || XM_ready !== !m_loading) begin bad++; $display("FAIL rnd_pend[%0d] got=%0b/%0d/%0b exp=%0b", i, pend_valid, pend_dst, XM_ready, m_loading); end
      total++; if (stall_cnt !== 16'(m_stall) || s_stall_cnt !== ((m_stall > 3) ? 2'd3 : 2'(m_stall))) begin bad++; $display("FAIL rnd_stall[%0d] got=%0d/%0d exp=%0d", i, stall_cnt, s_stall_cnt, m_stall); end
      total++; if (err_rsp !== m_err) begin bad++; $display("FAIL rnd_err[%0d] got=%0b exp=%0b", i, err_rsp, m_err); end
    end
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    model_reset();
    test_reset();
    test_alu_stream();
    test_load();
    test_alu_while_pending();
    test_unexpected_rsp();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
